// File: rtl/cic_decimator.sv
// cic_decimator: N-stage CIC decimation filter with an AXI-stream style
// handshake. Integrators run at the input rate. Every Reff-th accepted
// sample is passed on to a pipelined comb chain that runs at the output rate.
// All arithmetic wraps modulo 2^REG_WIDTH, which a CIC filter depends on.
module cic_decimator #(
    parameter int WIDTH     = 16,
    parameter int RMAX      = 2,
    parameter int M         = 1,
    parameter int N         = 2,
    parameter int REG_WIDTH = WIDTH + N * $clog2(RMAX * M)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [WIDTH-1:0]          input_tdata,
    input  logic                      input_tvalid,
    output logic                      input_tready,
    output logic [REG_WIDTH-1:0]      output_tdata,
    output logic                      output_tvalid,
    input  logic                      output_tready,
    input  logic [$clog2(RMAX+1)-1:0] rate
);

    localparam int RATE_W = $clog2(RMAX + 1);

    logic [REG_WIDTH-1:0] integ    [N];
    logic [REG_WIDTH-1:0] comb     [N];
    logic [REG_WIDTH-1:0] stage_in [N];
    logic [REG_WIDTH-1:0] dly      [N][M];
    logic [REG_WIDTH-1:0] sample_ext;
    logic [RATE_W-1:0]    cycle;
    logic [RATE_W-1:0]    reff;
    logic                 xfer;
    logic                 fire;

    // Input is only accepted when the output register is free to take a new
    // sample, so a pending output can never be overwritten.
    assign input_tready = !rst && (output_tready || !output_tvalid);
    assign xfer         = input_tvalid && input_tready;
    assign fire         = xfer && (cycle == '0);
    assign sample_ext   = REG_WIDTH'(signed'(input_tdata));
    assign output_tdata = comb[N-1];

    // Clamp the requested ratio into 1..RMAX.
    always_comb begin
        if (rate <= RATE_W'(1)) begin
            reff = RATE_W'(1);
        end else if (rate > RATE_W'(RMAX)) begin
            reff = RATE_W'(RMAX);
        end else begin
            reff = rate;
        end
    end

    // Stage inputs of the comb chain: last integrator, then previous comb.
    always_comb begin
        stage_in[0] = integ[N-1];
        for (int k = 1; k < N; k++) begin
            stage_in[k] = comb[k-1];
        end
    end

    // Integrator cascade, advancing once per accepted input sample.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < N; k++) begin
                integ[k] <= '0;
            end
        end else if (xfer) begin
            integ[0] <= integ[0] + sample_ext;
            for (int k = 1; k < N; k++) begin
                integ[k] <= integ[k] + integ[k-1];
            end
        end
    end

    // Decimation phase counter; the wrap test uses >= so a ratio lowered on
    // the fly pulls the counter back into range instead of running past it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle <= '0;
        end else if (xfer) begin
            if (cycle >= reff - RATE_W'(1)) begin
                cycle <= '0;
            end else begin
                cycle <= cycle + RATE_W'(1);
            end
        end
    end

    // Comb chain and its delay lines, clocked only on decimated samples.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < N; k++) begin
                comb[k] <= '0;
                for (int j = 0; j < M; j++) begin
                    dly[k][j] <= '0;
                end
            end
        end else if (fire) begin
            for (int k = 0; k < N; k++) begin
                comb[k]   <= stage_in[k] - dly[k][M-1];
                dly[k][0] <= stage_in[k];
                for (int j = 1; j < M; j++) begin
                    dly[k][j] <= dly[k][j-1];
                end
            end
        end
    end

    // Output valid: set on a fire (wins over a same-cycle handshake), else
    // cleared once the downstream takes the sample.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            output_tvalid <= 1'b0;
        end else if (fire) begin
            output_tvalid <= 1'b1;
        end else if (output_tready) begin
            output_tvalid <= 1'b0;
        end
    end

endmodule
